// File: rtl/seq_payload_capture_if.sv
// seq_payload_capture_if: valid/ready bundle for the captured payload word.
// master drives data/valid, slave drives ready.
interface seq_payload_capture_if #(
  parameter int PAYLOAD_W = 8
) ();
  logic [PAYLOAD_W-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/seq_payload_capture.sv
// seq_payload_capture: shifts PAYLOAD_W bits after a 1101 match into a
// one-deep valid/ready buffer. Define SEQ_PAYLOAD_STATS_EN for counters.
module seq_payload_capture #(
  parameter int PAYLOAD_W = 8,
  parameter int COUNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  din,
  input  logic                  match,
  seq_payload_capture_if.master out,
  output logic                  busy,
  output logic [COUNT_W-1:0]    frame_count,
  output logic [COUNT_W-1:0]    drop_count
);
  localparam int BW = $clog2(PAYLOAD_W) + 1;

  typedef enum logic {
    IDLE,
    CAPTURE
  } state_t;

  state_t               state_q, state_d;
  logic [PAYLOAD_W-1:0] sh_q, sh_d;
  logic [PAYLOAD_W-1:0] data_q, data_d;
  logic [PAYLOAD_W-1:0] word;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done;
  logic                 xfer;
  logic                 load;

  assign word = {sh_q[PAYLOAD_W-2:0], din};

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcnt_d  = bcnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    done    = 1'b0;
    xfer    = valid_q && out.out_ready;
    unique case (state_q)
      IDLE: begin
        if (match) begin
          sh_d    = word;
          bcnt_d  = BW'(1);
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // match is ignored here: payload bits may themselves hold 1101
        sh_d   = word;
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q == BW'(PAYLOAD_W - 1)) begin
          done    = 1'b1;
          bcnt_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    load = done && (!valid_q || xfer);
    if (load) begin
      data_d  = word;
      valid_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
    busy_d = (state_d == CAPTURE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bcnt_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcnt_q  <= bcnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign out.out_data  = data_q;
  assign out.out_valid = valid_q;
  assign busy          = busy_q;

`ifdef SEQ_PAYLOAD_STATS_EN
  logic [COUNT_W-1:0] frame_q, frame_d;
  logic [COUNT_W-1:0] drop_q, drop_d;
  logic               drop;

  assign drop = done && !load;

  always_comb begin
    frame_d = frame_q + COUNT_W'(load);
    drop_d  = drop_q + COUNT_W'(drop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q <= '0;
      drop_q  <= '0;
    end else begin
      frame_q <= frame_d;
      drop_q  <= drop_d;
    end
  end

  assign frame_count = frame_q;
  assign drop_count  = drop_q;
`else
  assign frame_count = '0;
  assign drop_count  = '0;
`endif
endmodule

// File: tb/tb_seq_payload_capture.sv
// tb_seq_payload_capture: directed vectors for seq_payload_capture.
// Counter expectations follow SEQ_PAYLOAD_STATS_EN.
module tb_seq_payload_capture;
  logic        clk = 1'b0;
  logic        reset;
  logic        din;
  logic        match;
  logic        busy;
  logic [15:0] frame_count;
  logic [15:0] drop_count;
  int          checks = 0;
  int          failures = 0;

  seq_payload_capture_if #(.PAYLOAD_W(8)) sif ();

  seq_payload_capture #(
    .PAYLOAD_W(8),
    .COUNT_W  (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .match      (match),
    .out        (sif),
    .busy       (busy),
    .frame_count(frame_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] cnt(input int n);
`ifdef SEQ_PAYLOAD_STATS_EN
    return 32'(n);
`else
    return 32'(0 * n);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic d, input logic m);
    din   = d;
    match = m;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    din   = 1'b0;
    match = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] p, input int mm,
                            input bit rdy_last);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (rdy_last && i == 7) sif.out_ready = 1'b1;
      tick(p[7-i], (i == 0) || (i == mm));
      if (i == 0) chk("busy_start", 32'(busy), 1);
    end
    if (rdy_last) sif.out_ready = 1'b0;
    chk("busy_end", 32'(busy), 0);
  endtask

  initial begin
    sif.out_ready = 1'b0;
    reset = 1'b1;
    din   = 1'b0;
    match = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(sif.out_valid), 0);
    chk("rst_data", 32'(sif.out_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frames", 32'(frame_count), 0);
    chk("rst_drops", 32'(drop_count), 0);
    reset = 1'b0;

    // basic capture
    sif.out_ready = 1'b1;
    tick(1'b0, 1'b0);
    send_frame(8'hA5, -1, 1'b0);
    chk("basic_valid", 32'(sif.out_valid), 1);
    chk("basic_data", 32'(sif.out_data), 32'hA5);
    chk("basic_frames", 32'(frame_count), cnt(1));
    tick(1'b0, 1'b0);
    chk("basic_valid_off", 32'(sif.out_valid), 0);

    // backpressure and drop
    do_reset();
    sif.out_ready = 1'b0;
    send_frame(8'h3C, -1, 1'b0);
    chk("bp_valid1", 32'(sif.out_valid), 1);
    chk("bp_data1", 32'(sif.out_data), 32'h3C);
    tick(1'b0, 1'b0);
    send_frame(8'hF0, -1, 1'b0);
    chk("bp_hold_data", 32'(sif.out_data), 32'h3C);
    chk("bp_hold_valid", 32'(sif.out_valid), 1);
    chk("bp_frames", 32'(frame_count), cnt(1));
    chk("bp_drops", 32'(drop_count), cnt(1));
    sif.out_ready = 1'b1;
    tick(1'b0, 1'b0);
    sif.out_ready = 1'b0;
    chk("bp_drain_valid", 32'(sif.out_valid), 0);

    // simultaneous transfer and completion
    do_reset();
    send_frame(8'h3C, -1, 1'b0);
    tick(1'b0, 1'b0);
    send_frame(8'h96, -1, 1'b1);
    chk("sim_data", 32'(sif.out_data), 32'h96);
    chk("sim_valid", 32'(sif.out_valid), 1);
    chk("sim_drops", 32'(drop_count), cnt(0));
    chk("sim_frames", 32'(frame_count), cnt(2));
    tick(1'b0, 1'b0);
    chk("sim_hold", 32'(sif.out_data), 32'h96);

    // match asserted mid-payload is ignored
    do_reset();
    sif.out_ready = 1'b1;
    send_frame(8'hDD, 4, 1'b0);
    chk("mid_data", 32'(sif.out_data), 32'hDD);
    chk("mid_valid", 32'(sif.out_valid), 1);
    tick(1'b0, 1'b0);
    chk("mid_valid_off", 32'(sif.out_valid), 0);
    repeat (6) tick(1'b0, 1'b0);
    chk("mid_no_2nd_busy", 32'(busy), 0);
    chk("mid_no_2nd_valid", 32'(sif.out_valid), 0);
    chk("mid_frames", 32'(frame_count), cnt(1));

    // reset mid-capture (out_data still holds 0xDD here)
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk("pre_rst_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_valid", 32'(sif.out_valid), 0);
    chk("mrst_data", 32'(sif.out_data), 0);
    chk("mrst_frames", 32'(frame_count), 0);
    chk("mrst_drops", 32'(drop_count), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("post_rst_busy", 32'(busy), 0);
    send_frame(8'h5A, -1, 1'b0);
    chk("fresh_data", 32'(sif.out_data), 32'h5A);
    chk("fresh_valid", 32'(sif.out_valid), 1);
    chk("fresh_frames", 32'(frame_count), cnt(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
